// File: rtl/noc_tx_packetizer.sv
// Endpoint-to-mesh injection: accepts a whole packet, serialises it into flits and
// issues them to the router only while the local credit mirror shows buffer space.
module noc_tx_packetizer #(
   parameter  int FLIT_WIDTH        = 256,
   parameter  int DEST_WIDTH        = 4,
   parameter  int FLIT_BUFFER_DEPTH = 2,
   parameter  int MAX_FLITS         = 4,
   parameter  int LEN_WIDTH         = 3,
   localparam int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            pkt_valid,
   output logic                            pkt_ready,
   input  logic [FLIT_WIDTH*MAX_FLITS-1:0] pkt_data,
   input  logic [DEST_WIDTH-1:0]           pkt_dest,
   input  logic [LEN_WIDTH-1:0]            pkt_len,
   output logic [FLIT_WIDTH-1:0]           data_out,
   output logic [DEST_WIDTH-1:0]           dest_out,
   output logic                            is_tail_out,
   output logic                            send_out,
   input  logic                            credit_in,
   output logic [CREDIT_WIDTH-1:0]         credit_count,
   output logic                            credit_err
);
   localparam int IDX_WIDTH = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
   localparam logic [LEN_WIDTH-1:0]    LEN_MAX    = LEN_WIDTH'(MAX_FLITS);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                 state;
   logic [FLIT_WIDTH-1:0]  flits [MAX_FLITS];
   logic [DEST_WIDTH-1:0]  dest_q;
   logic [IDX_WIDTH-1:0]   idx;
   logic [IDX_WIDTH-1:0]   last_idx;
   logic [LEN_WIDTH-1:0]   eff_len;
   logic                   accept;
   logic                   issue;
   logic                   is_last;

   // Packet handshake: a packet transfers on a rising edge where pkt_valid and
   // pkt_ready are both high; pkt_ready depends only on state and rst, never on pkt_valid.
   assign pkt_ready = (state == IDLE) && !rst;
   assign accept    = pkt_valid && pkt_ready;
   assign issue     = (state == SEND) && (credit_count != '0);
   assign is_last   = (idx == last_idx);

   always_comb begin
      eff_len = pkt_len;
      if (pkt_len == '0) begin
         eff_len = LEN_WIDTH'(1);
      end else if (pkt_len > LEN_MAX) begin
         eff_len = LEN_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < MAX_FLITS; k++) begin
            flits[k] <= pkt_data[k*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         last_idx     <= '0;
         dest_q       <= '0;
         data_out     <= '0;
         dest_out     <= '0;
         is_tail_out  <= 1'b0;
         send_out     <= 1'b0;
         credit_count <= CREDIT_MAX;
         credit_err   <= 1'b0;
      end else begin
         send_out    <= issue;
         is_tail_out <= issue && is_last;
         case (state)
            IDLE: begin
               if (accept) begin
                  dest_q   <= pkt_dest;
                  last_idx <= IDX_WIDTH'(eff_len - LEN_WIDTH'(1));
                  idx      <= '0;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (issue) begin
                  data_out <= flits[idx];
                  dest_out <= dest_q;
                  idx      <= idx + IDX_WIDTH'(1);
                  if (is_last) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // A credit arriving while the mirror is full means the router returned more than it took.
         case ({issue, credit_in})
            2'b10: credit_count <= credit_count - CREDIT_WIDTH'(1);
            2'b01: begin
               if (credit_count == CREDIT_MAX) begin
                  credit_err <= 1'b1;
               end else begin
                  credit_count <= credit_count + CREDIT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/noc_tx_packetizer.md
# noc_tx_packetizer

Endpoint-side injection block that drives one mesh NoC input port (`data_in`/`dest_in`/`is_tail_in`/`send_in`, `credit_out`). It accepts a whole packet of up to MAX_FLITS flits over a valid/ready handshake. It serialises the packet into flits on the NoC side and tags the last flit as tail. Flits are issued only against a local credit counter, which mirrors the free slots in the attached router's input buffer. One instance sits between each endpoint and its mesh port.

## Interface
- FLIT_WIDTH, 256, flit payload width
- DEST_WIDTH, 4, destination endpoint id width
- FLIT_BUFFER_DEPTH, 2, router input buffer depth; initial and maximum credit count
- MAX_FLITS, 4, maximum flits per packet
- LEN_WIDTH, 3, width of pkt_len; must hold MAX_FLITS
- clk  in  1  clock
- rst  in  1  reset
  - synchronous, active-high
  - one clock domain
- pkt_valid  in  1  packet offered
- pkt_ready  out  1  packet accepted when pkt_valid & pkt_ready
- pkt_data  in  FLIT_WIDTH*MAX_FLITS  packet payload; flit k = bits [k*FLIT_WIDTH +: FLIT_WIDTH]
- pkt_dest  in  DEST_WIDTH  destination id
- pkt_len  in  LEN_WIDTH  flit count, 1..MAX_FLITS
- data_out  out  FLIT_WIDTH  flit to router
- dest_out  out  DEST_WIDTH  destination, identical on every flit of a packet
- is_tail_out  out  1  last flit of packet, qualified by send_out
- send_out  out  1  flit valid, one cycle per flit
- credit_in  in  1  single-cycle pulse, returns one credit
- credit_count  out  clog2(FLIT_BUFFER_DEPTH+1)  current credits
- credit_err  out  1  sticky; credit returned while counter at maximum

## Operation
- FSM with two states.
- IDLE:
  - pkt_ready=1.
  - On accept: capture pkt_data, pkt_dest and pkt_len; clear flit index; go to SEND.
  - pkt_len=0 is treated as 1.
  - pkt_len>MAX_FLITS is clamped to MAX_FLITS.
- SEND:
  - pkt_ready=0.
  - issue = (credit_count != 0).
  - On issue, the next edge sets send_out=1, data_out=flit[index], dest_out=captured dest, is_tail_out=(index==len-1), and increments the index.
  - After the tail flit is issued, go to IDLE.
  - Without credit: send_out=0 and the index holds; stall indefinitely.
- Credit counter:
  - next = count - issue + credit_in.
  - Simultaneous issue and credit_in leave the count unchanged.
  - The counter never underflows, because issue requires count>0.
  - credit_in while count==FLIT_BUFFER_DEPTH and no issue in that cycle: count stays at FLIT_BUFFER_DEPTH and credit_err sets. credit_err stays set until rst.
- Reset mid-packet:
  - The in-flight packet is abandoned; no further flits are sent.
  - The FSM returns to IDLE.
  - Credits restore to FLIT_BUFFER_DEPTH. The router shares rst, so its buffer is also emptied.
- Reset values:
  - send_out=0, is_tail_out=0, data_out=0, dest_out=0.
  - pkt_ready=0 during rst; 1 in the first cycle after rst deasserts.
  - credit_count=FLIT_BUFFER_DEPTH, credit_err=0.

## Timing
- Accept edge T → first flit on send_out in cycle T+1, if credits are available.
- Full credit supply: one flit per cycle, so an L-flit packet occupies cycles T+1..T+L.
- pkt_ready returns in the cycle after the tail flit is issued (the cycle in which send_out shows the tail). Minimum packet-to-packet spacing is therefore L+1 cycles.
- All NoC-side outputs are registered.
- data_out and dest_out hold their last values while send_out=0.
- is_tail_out is 0 whenever send_out=0.
- A credit_in pulse at edge E allows an issue decision in the cycle after E. That flit is visible at the following edge.
- pkt_data, pkt_dest and pkt_len may change freely after acceptance.

## Test plan
- Reset then idle (DEPTH=2):
  - credit_count=2, pkt_ready=1, send_out=0.
  - Holding credit_in=0 for 20 cycles changes nothing.
- 4-flit packet with flits 0xA,0xB,0xC,0xD, dest=3, DEPTH=2, credits returned 3 cycles after each send:
  - Flits A and B appear on consecutive cycles, then a stall until the first credit returns.
  - Order is A,B,C,D; dest_out=3 on all four; is_tail_out only on D.
  - Final credit_count=2.
- 1-flit packets offered back-to-back with credit_in tied to send_out delayed one cycle:
  - Each packet is a single send_out with is_tail_out=1.
  - pkt_ready toggles with period 2.
  - credit_count never drops below 1.
- Same-cycle send and credit_in:
  - With count=1, a flit issues while credit_in=1 → count stays 1.
  - With count=0 and credit_in=1 → the next cycle issues.
- Extra credit_in while count=2 and no send:
  - count stays 2; credit_err=1 and stays set until rst.
- rst asserted after the 2nd flit of a 4-flit packet:
  - No further send_out.
  - credit_count=2, pkt_ready=1 after rst.
  - The next packet's first flit is its own flit 0.
